// File: rtl/uart_receiver.sv
// UART 8N1 receive stage with an APB read-only data/status register pair.
// Registers sit in the upper address half (PADDR[7]=1): 0x80 RXDATA, 0x81 STATUS.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [7:0] PADDR,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_Done,
  output logic       o_Rx_Error
);

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] BIT_HALF = 16'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT,
    CLEANUP
  } state_t;

  state_t      state_q,     state_d;
  logic [15:0] cnt_q,       cnt_d;
  logic [2:0]  bit_idx_q,   bit_idx_d;
  logic [7:0]  shift_q,     shift_d;
  logic [7:0]  hold_q,      hold_d;
  logic        valid_q,     valid_d;
  logic        overrun_q,   overrun_d;
  logic        frame_err_q, frame_err_d;
  logic        done_q,      done_d;
  logic        rx_meta_q;
  logic        rx_s_q;

  logic apb_access;
  logic rd_data;
  logic rd_stat;

  assign apb_access = PSEL & PENABLE & ~PWRITE & PADDR[7];
  assign rd_data    = apb_access && (PADDR == 8'h80);
  assign rd_stat    = apb_access && (PADDR == 8'h81);

  // Two-flop synchronizer for the asynchronous serial line; resets to idle-high.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_Rx_Serial;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Next-state logic for the receive FSM, holding register and status flags.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    done_d      = 1'b0;

    // Read-side clears first so that a simultaneous set below wins.
    if (rd_data) valid_d = 1'b0;
    if (rd_stat) begin
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!rx_s_q) state_d = START_BIT;
      end
      START_BIT: begin
        if (cnt_q == BIT_HALF) begin
          cnt_d   = '0;
          state_d = rx_s_q ? IDLE : DATA_BITS;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA_BITS: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s_q;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP_BIT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP_BIT: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = CLEANUP;
          if (rx_s_q) done_d      = 1'b1;
          else        frame_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      CLEANUP: begin
        cnt_d   = '0;
        state_d = IDLE;
        // The holding register is written at the end of the cycle in which
        // o_Rx_Done is high, so a read in that cycle still sees the old byte.
        if (done_q) begin
          hold_d  = shift_q;
          valid_d = 1'b1;
          if (valid_q && !rd_data) overrun_d = 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      done_q      <= done_d;
    end
  end

  // Zero-wait-state APB read mux; silent outside an upper-half read access.
  always_comb begin
    PREADY = apb_access;
    PRDATA = '0;
    if (apb_access) begin
      case (PADDR)
        8'h80:   PRDATA = hold_q;
        8'h81:   PRDATA = {5'b0, overrun_q, frame_err_q, valid_q};
        default: PRDATA = '0;
      endcase
    end
  end

  assign o_Rx_Done  = done_q;
  assign o_Rx_Error = frame_err_q;

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Serial-to-parallel UART receive stage. It consumes the 8N1 serial stream produced by the team's UART transmitter. It can also take an external line. Received bytes are exposed to the APB bus through a read-only data/status register pair in the upper address half (PADDR[7]=1). The lower half belongs to the transmit side. The block holds one byte, flags framing errors and overruns, and pulses a done strobe per good byte.

Parameters:
CLKS_PER_BIT, 87, PCLK cycles per serial bit (legal range 4..65535).

Ports:
PCLK  in  1  APB/system clock; all logic on rising edge
PRESET  in  1  reset, asynchronous, active-high
PSEL  in  1  APB select for this slave
PENABLE  in  1  APB access-phase qualifier
PWRITE  in  1  APB direction (1=write); writes are ignored
PADDR  in  8  APB address; 0x80=RXDATA, 0x81=STATUS
PRDATA  out  8  APB read data
PREADY  out  1  APB ready
i_Rx_Serial  in  1  serial input, idle high, asynchronous to PCLK
o_Rx_Done  out  1  one-cycle pulse when a good byte is loaded
o_Rx_Error  out  1  level; framing-error sticky flag

Behaviour:
- Reset is asynchronous and active-high.
  - All registers are cleared on PRESET, including the state, counter, bit index, shift register, holding register and flags.
  - Both synchronizer flops are set to 1 (idle).
  - Output reset values: PRDATA=0, PREADY=0, o_Rx_Done=0, o_Rx_Error=0.
  - Reset mid-frame aborts the frame. No flag is set.
- Input path: 2-flop synchronizer on i_Rx_Serial. All FSM decisions use the synchronized bit (rx_s).
- Counter: 16-bit, cleared on every state change.
- FSM states: IDLE, START_BIT, DATA_BITS, STOP_BIT, CLEANUP.
  - IDLE: counter=0, bit index=0. rx_s=0 -> START_BIT.
  - START_BIT: when counter reaches (CLKS_PER_BIT-1)/2 (mid-bit), check rx_s.
    - rx_s=0 -> DATA_BITS.
    - rx_s=1 -> glitch, IDLE; no flag is set.
  - DATA_BITS: every CLKS_PER_BIT cycles, sample rx_s into shift[bit_index]. Data is LSB first.
    - After bit 7 -> STOP_BIT.
    - Bit index is 3 bits and wraps 7->0 on exit.
  - STOP_BIT: sample rx_s after CLKS_PER_BIT cycles.
    - rx_s=1: load the holding register with the shift register and set valid=1. o_Rx_Done=1 for exactly the next cycle.
    - rx_s=0: set frame_err=1. The holding register and valid are unchanged.
    - Either case -> CLEANUP.
  - CLEANUP: one cycle, clears o_Rx_Done -> IDLE.
  - A line still low in IDLE after a framing error re-enters START_BIT. This is accepted behaviour.
- Overrun: a good byte completing while valid=1 overwrites the holding register and sets overrun=1.
- APB read (zero wait state):
  - Access-phase condition: PSEL & PENABLE & !PWRITE & PADDR[7].
  - In the access phase, PREADY=1 combinationally and PRDATA is driven.
  - Outside the access phase, PREADY=0 and PRDATA=0.
  - 0x80 RXDATA: returns the holding register and clears valid at the end of the access cycle.
  - 0x81 STATUS: returns {5'b0, overrun, frame_err, valid}. Clears overrun and frame_err at the end of the access cycle.
  - Other addresses with PADDR[7]=1: return 0 with PREADY=1.
  - Writes and PADDR[7]=0 accesses: PREADY=0; this block does not respond.
- Simultaneous events:
  - RXDATA read in the same cycle a good byte loads: the new byte wins, valid stays 1, overrun is not set. The read returns the old byte.
  - STATUS read in the same cycle frame_err or overrun sets: the set wins and the flag stays 1.
- o_Rx_Error mirrors frame_err.

Test Plan:
- CLKS_PER_BIT=8, send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> o_Rx_Done pulses once about 78 cycles after the start edge. STATUS=0x01. RXDATA read returns 0xA5 with PREADY=1. Next STATUS=0x00.
- Send 0x3C with the stop bit held 0 -> STATUS=0x02 and o_Rx_Error=1. valid=0 and no o_Rx_Done. STATUS read clears it to 0x00.
- Send 0x11 then 0x22 without reading -> STATUS=0x05. RXDATA=0x22.
- Apply a 2-cycle low glitch on the idle line -> FSM returns to IDLE. No done pulse, STATUS=0x00. A following 0x5A frame is received correctly.
- Assert PRESET during DATA_BITS of 0xFF -> all outputs 0 immediately and FSM in IDLE. A subsequent 0x81 frame is received correctly.
- RXDATA read issued in the exact cycle o_Rx_Done rises for a second byte (first byte 0x01, second 0x02) -> the read returns 0x01. STATUS=0x01 (valid set, no overrun). The following RXDATA read returns 0x02.
